// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer with a registered one-cycle lookup,
// per-entry saturating direction counters, per-set round-robin replacement and a flush sweep.
module btb_assoc #(
    parameter int WAYS         = 2,
    parameter int SETS         = 16,
    parameter int TAG_WIDTH    = 9,
    parameter int PC_WIDTH     = 13,
    parameter int TARGET_WIDTH = 32,
    parameter int CTR_WIDTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lookup_valid,
    input  logic [PC_WIDTH-1:0]     lookup_pc,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [TARGET_WIDTH-1:0] resp_target,
    output logic                    resp_is_branch,
    output logic                    resp_is_jump,
    output logic                    resp_taken,
    input  logic                    upd_valid,
    input  logic [PC_WIDTH-1:0]     upd_pc,
    input  logic [TARGET_WIDTH-1:0] upd_target,
    input  logic                    upd_is_branch,
    input  logic                    upd_taken,
    input  logic                    flush,
    output logic                    busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WT - CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};

    typedef enum logic [0:0] {IDLE, SWEEP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        sweep_q, sweep_d;

    logic [WAYS-1:0]         valid_q  [SETS];
    logic [PTR_W-1:0]        vptr_q   [SETS];
    logic [TAG_WIDTH-1:0]    tag_q    [SETS][WAYS];
    logic [TARGET_WIDTH-1:0] target_q [SETS][WAYS];
    logic                    isbr_q   [SETS][WAYS];
    logic [CTR_WIDTH-1:0]    ctr_q    [SETS][WAYS];

    logic                    resp_valid_q, resp_hit_q, resp_br_q, resp_jmp_q, resp_taken_q;
    logic                    resp_valid_d, resp_hit_d, resp_br_d, resp_jmp_d, resp_taken_d;
    logic [TARGET_WIDTH-1:0] resp_target_q, resp_target_d;

    logic [IDX_W-1:0]        l_idx, u_idx;
    logic [TAG_WIDTH-1:0]    l_tag, u_tag;
    logic [WAYS-1:0]         l_match, u_match, u_free;
    logic [PTR_W-1:0]        l_way, u_hit_way, u_free_way, u_way;
    logic                    u_hit, u_has_free, u_replace, upd_en;
    logic [CTR_WIDTH-1:0]    ctr_cur, ctr_new;

    assign l_idx = lookup_pc[IDX_W-1:0];
    assign l_tag = lookup_pc[PC_WIDTH-1:IDX_W];
    assign u_idx = upd_pc[IDX_W-1:0];
    assign u_tag = upd_pc[PC_WIDTH-1:IDX_W];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign l_match[gi] = valid_q[l_idx][gi] && (tag_q[l_idx][gi] == l_tag);
            assign u_match[gi] = valid_q[u_idx][gi] && (tag_q[u_idx][gi] == u_tag);
            assign u_free[gi]  = !valid_q[u_idx][gi];
        end
    endgenerate

    // Descending scans leave the lowest matching / free way selected.
    always_comb begin
        l_way      = '0;
        u_hit_way  = '0;
        u_free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (l_match[w]) l_way      = PTR_W'(w);
            if (u_match[w]) u_hit_way  = PTR_W'(w);
            if (u_free[w])  u_free_way = PTR_W'(w);
        end
    end

    always_comb begin
        resp_valid_d  = lookup_valid;
        resp_hit_d    = 1'b0;
        resp_target_d = '0;
        resp_br_d     = 1'b0;
        resp_jmp_d    = 1'b0;
        resp_taken_d  = 1'b0;
        if (lookup_valid && (state_q == IDLE) && (|l_match)) begin
            resp_hit_d    = 1'b1;
            resp_target_d = target_q[l_idx][l_way];
            resp_br_d     = isbr_q[l_idx][l_way];
            resp_jmp_d    = !isbr_q[l_idx][l_way];
            resp_taken_d  = !isbr_q[l_idx][l_way] || ctr_q[l_idx][l_way][CTR_WIDTH-1];
        end
    end

    assign u_hit      = |u_match;
    assign u_has_free = |u_free;
    assign u_replace  = !u_hit && !u_has_free;
    assign u_way      = u_hit ? u_hit_way : (u_has_free ? u_free_way : vptr_q[u_idx]);
    assign upd_en     = upd_valid && (state_q == IDLE) && !flush;
    assign ctr_cur    = ctr_q[u_idx][u_way];

    always_comb begin
        ctr_new = ctr_cur;
        if (u_hit) begin
            if (upd_is_branch) begin
                if (upd_taken && (ctr_cur != CTR_MAX))   ctr_new = ctr_cur + 1'b1;
                else if (!upd_taken && (ctr_cur != '0))  ctr_new = ctr_cur - 1'b1;
            end
        end else begin
            ctr_new = (upd_taken || !upd_is_branch) ? CTR_WT : CTR_WNT;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = SWEEP;
                    sweep_d = '0;
                end
            end
            SWEEP: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else if (state_q == SWEEP) begin
            valid_q[sweep_q] <= '0;
            vptr_q[sweep_q]  <= '0;
        end else if (upd_en) begin
            valid_q[u_idx][u_way] <= 1'b1;
            if (u_replace)
                vptr_q[u_idx] <= (vptr_q[u_idx] == PTR_W'(WAYS - 1)) ? '0 : vptr_q[u_idx] + 1'b1;
        end
    end

    // Payload storage carries no reset; valid bits alone qualify an entry.
    always_ff @(posedge clk) begin
        if (upd_en) begin
            tag_q[u_idx][u_way]    <= u_tag;
            target_q[u_idx][u_way] <= upd_target;
            isbr_q[u_idx][u_way]   <= upd_is_branch;
            ctr_q[u_idx][u_way]    <= ctr_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_target_q <= '0;
            resp_br_q     <= 1'b0;
            resp_jmp_q    <= 1'b0;
            resp_taken_q  <= 1'b0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            resp_target_q <= resp_target_d;
            resp_br_q     <= resp_br_d;
            resp_jmp_q    <= resp_jmp_d;
            resp_taken_q  <= resp_taken_d;
        end
    end

    assign resp_valid     = resp_valid_q;
    assign resp_hit       = resp_hit_q;
    assign resp_target    = resp_target_q;
    assign resp_is_branch = resp_br_q;
    assign resp_is_jump   = resp_jmp_q;
    assign resp_taken     = resp_taken_q;
    assign busy           = (state_q == SWEEP);

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc: lookup, counters, replacement,
// read-before-write, flush sweep and asynchronous reset.
module tb_btb_assoc;
    logic        clk;
    logic        rst;
    logic        lookup_valid;
    logic [12:0] lookup_pc;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_target;
    logic        resp_is_branch;
    logic        resp_is_jump;
    logic        resp_taken;
    logic        upd_valid;
    logic [12:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_is_branch;
    logic        upd_taken;
    logic        flush;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;

    btb_assoc dut (
        .clk            (clk),
        .rst            (rst),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_target    (resp_target),
        .resp_is_branch (resp_is_branch),
        .resp_is_jump   (resp_is_jump),
        .resp_taken     (resp_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_is_branch  (upd_is_branch),
        .upd_taken      (upd_taken),
        .flush          (flush),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [12:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        cycle();
        lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [12:0] pc, input logic [31:0] tgt, input logic br, input logic tk);
        upd_valid     = 1'b1;
        upd_pc        = pc;
        upd_target    = tgt;
        upd_is_branch = br;
        upd_taken     = tk;
        cycle();
        upd_valid = 1'b0;
    endtask

    task automatic check_resp(input string tag, input logic hit, input logic [31:0] tgt,
                              input logic br, input logic jmp, input logic tk);
        check_eq({tag, ".valid"},  32'(resp_valid),     32'd1);
        check_eq({tag, ".hit"},    32'(resp_hit),       32'(hit));
        check_eq({tag, ".target"}, resp_target,         tgt);
        check_eq({tag, ".branch"}, 32'(resp_is_branch), 32'(br));
        check_eq({tag, ".jump"},   32'(resp_is_jump),   32'(jmp));
        check_eq({tag, ".taken"},  32'(resp_taken),     32'(tk));
    endtask

    task automatic look_miss(input string tag, input logic [12:0] pc);
        lookup(pc);
        check_resp(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_target = '0; upd_is_branch = 1'b0; upd_taken = 1'b0; flush = 1'b0;
        #2;
        check_eq("rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst.busy",       32'(busy),       32'd0);
        #20 rst = 1'b0;
        cycle();

        look_miss("cold", 13'h015);
        check_eq("cold.busy", 32'(busy), 32'd0);
        cycle();
        check_eq("idle.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("idle.target",     resp_target,     32'd0);

        // Counter: fill taken -> 10, NT -> 01 -> 00 -> 00, T -> 01 -> 10 -> 11 -> 11
        update(13'h015, 32'h40, 1'b1, 1'b1);
        lookup(13'h015); check_resp("fill_t", 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        update(13'h015, 32'h40, 1'b1, 1'b0);
        lookup(13'h015); check_resp("nt1", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        update(13'h015, 32'h40, 1'b1, 1'b0);
        update(13'h015, 32'h40, 1'b1, 1'b0);
        lookup(13'h015); check_resp("nt_sat", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        update(13'h015, 32'h40, 1'b1, 1'b1);
        lookup(13'h015); check_resp("t_from00", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        update(13'h015, 32'h40, 1'b1, 1'b1);
        lookup(13'h015); check_resp("t_to10", 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        update(13'h015, 32'h40, 1'b1, 1'b1);
        update(13'h015, 32'h40, 1'b1, 1'b1);
        lookup(13'h015); check_resp("t_sat", 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);

        // Same-cycle lookup and update: old contents returned
        lookup_valid = 1'b1; lookup_pc = 13'h015;
        upd_valid = 1'b1; upd_pc = 13'h015; upd_target = 32'h80; upd_is_branch = 1'b1; upd_taken = 1'b1;
        cycle();
        lookup_valid = 1'b0; upd_valid = 1'b0;
        check_resp("rbw_old", 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        lookup(13'h015); check_resp("rbw_new", 1'b1, 32'h80, 1'b1, 1'b0, 1'b1);

        // Round-robin replacement in set 5
        update(13'h015, 32'h100, 1'b0, 1'b0);
        update(13'h025, 32'h200, 1'b0, 1'b0);
        update(13'h035, 32'h300, 1'b0, 1'b0);
        look_miss("evict015", 13'h015);
        lookup(13'h025); check_resp("keep025", 1'b1, 32'h200, 1'b0, 1'b1, 1'b1);
        lookup(13'h035); check_resp("new035",  1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
        update(13'h045, 32'h400, 1'b1, 1'b0);
        look_miss("evict025", 13'h025);
        lookup(13'h045); check_resp("new045",  1'b1, 32'h400, 1'b1, 1'b0, 1'b0);
        lookup(13'h035); check_resp("keep035", 1'b1, 32'h300, 1'b0, 1'b1, 1'b1);

        update(13'h016, 32'h55, 1'b0, 1'b0);
        lookup(13'h016); check_resp("set6", 1'b1, 32'h55, 1'b0, 1'b1, 1'b1);
        look_miss("set6_tag0", 13'h006);

        // Flush with a same-cycle update that must be dropped
        flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 13'h017; upd_target = 32'h77; upd_is_branch = 1'b0; upd_taken = 1'b0;
        cycle();
        flush = 1'b0; upd_valid = 1'b0;
        check_eq("flush.busy_rise", 32'(busy), 32'd1);
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 40 && busy; i++) begin
            if (i == 4) begin
                lookup_valid = 1'b1; lookup_pc = 13'h035;
                upd_valid = 1'b1; upd_pc = 13'h020; upd_target = 32'h99; upd_is_branch = 1'b0;
            end
            cycle();
            lookup_valid = 1'b0; upd_valid = 1'b0;
            if (i == 4) check_resp("sweep_lookup", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            if (busy) busy_cnt++;
        end
        check_eq("flush.busy_cycles", 32'(busy_cnt), 32'd16);
        look_miss("post035", 13'h035);
        look_miss("post045", 13'h045);
        look_miss("post016", 13'h016);
        look_miss("post020_dropped", 13'h020);
        look_miss("post017_dropped", 13'h017);

        // Asynchronous reset in the middle of a sweep with an update pending
        update(13'h016, 32'h66, 1'b0, 1'b0);
        lookup(13'h016); check_resp("pre_rst", 1'b1, 32'h66, 1'b0, 1'b1, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        lookup_valid = 1'b1; lookup_pc = 13'h016;
        upd_valid = 1'b1; upd_pc = 13'h027; upd_target = 32'h12; upd_is_branch = 1'b1; upd_taken = 1'b1;
        cycle(); cycle();
        check_eq("pre_rst.busy",       32'(busy),       32'd1);
        check_eq("pre_rst.resp_valid", 32'(resp_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst.busy",       32'(busy),       32'd0);
        check_eq("async_rst.resp_valid", 32'(resp_valid), 32'd0);
        check_eq("async_rst.resp_hit",   32'(resp_hit),   32'd0);
        cycle();
        lookup_valid = 1'b0; upd_valid = 1'b0;
        #2 rst = 1'b0;
        cycle();
        check_eq("post_rst.busy", 32'(busy), 32'd0);
        look_miss("post_rst016", 13'h016);
        look_miss("post_rst027", 13'h027);
        update(13'h027, 32'h77, 1'b1, 1'b1);
        lookup(13'h027); check_resp("post_rst_fill", 1'b1, 32'h77, 1'b1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
